// File: rtl/result_score_bcd.sv
// Binary score to 4-digit BCD converter for the result screen.
// Uses an iterative double-dabble engine; outputs are held stable and change only when a conversion completes.

module result_score_bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module result_score_bcd #(
    parameter int SCORE_W = 14,
    parameter int SAT_MAX = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    input  logic               mode_in,
    input  logic               win_in,
    output logic               busy,
    output logic               done,
    output logic               mode,
    output logic               win,
    output logic [1:0]         digit,
    output logic [3:0]         a0,
    output logic [3:0]         a1,
    output logic [3:0]         a2,
    output logic [3:0]         a3
);
    localparam int NIB   = 4;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [31:0]      SAT_L = 32'(SAT_MAX);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} state_t;

    state_t                  state;
    logic [SCORE_W-1:0]      bin;
    logic [NIB-1:0][3:0]     bcd;
    logic [NIB-1:0][3:0]     bcd_adj;
    logic [CNT_W-1:0]        cnt;
    logic                    mode_h;
    logic                    win_h;
    logic [SCORE_W-1:0]      load_val;
    logic [1:0]              digit_nx;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            result_score_bcd_add3 u_add3 (.d(bcd[gi]), .q(bcd_adj[gi]));
        end
    endgenerate

    // Clamp on the full-width value so wide scores can never overflow the 4 nibbles.
    always_comb begin
        load_val = score;
        if (32'(score) > SAT_L)
            load_val = SAT_L[SCORE_W-1:0];
    end

    always_comb begin
        digit_nx = 2'd0;
        if (bcd[3] != 4'd0)      digit_nx = 2'd3;
        else if (bcd[2] != 4'd0) digit_nx = 2'd2;
        else if (bcd[1] != 4'd0) digit_nx = 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            mode_h <= 1'b0;
            win_h  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode   <= 1'b0;
            win    <= 1'b0;
            digit  <= 2'd0;
            a0     <= 4'd0;
            a1     <= 4'd0;
            a2     <= 4'd0;
            a3     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin    <= load_val;
                        bcd    <= '0;
                        cnt    <= '0;
                        mode_h <= mode_in;
                        win_h  <= win_in;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FINAL;
                end
                FINAL: begin
                    a0    <= bcd[0];
                    a1    <= bcd[1];
                    a2    <= bcd[2];
                    a3    <= bcd[3];
                    digit <= digit_nx;
                    mode  <= mode_h;
                    win   <= win_h;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_score_bcd.sv
// Directed bench for result_score_bcd: latency, digit values, clamping, overlap and async reset.

module tb_result_score_bcd;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [13:0] score = '0;
    logic        mode_in = 1'b0;
    logic        win_in = 1'b0;
    logic        busy, done, mode, win;
    logic [1:0]  digit;
    logic [3:0]  a0, a1, a2, a3;

    int vec = 0;
    int miscmp = 0;
    int n;
    int bad;

    result_score_bcd dut (
        .clk(clk), .rst(rst), .start(start), .score(score),
        .mode_in(mode_in), .win_in(win_in), .busy(busy), .done(done),
        .mode(mode), .win(win), .digit(digit),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return {12'd0, mode, win, digit, a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            miscmp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start across one edge (edge T), then sample 1 time unit later.
    task automatic launch(input logic [13:0] sc, input logic m, input logic w);
        score = sc; mode_in = m; win_in = w; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait for done; meanwhile busy must stay high and outputs must not move.
    task automatic wait_done(input int n0, output int cycles);
        logic [31:0] prev;
        int errs;
        prev = outs();
        errs = 0;
        cycles = n0;
        while (cycles < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (done) break;
            if (!busy || outs() !== prev) errs++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", 32'(cycles), 32'd15);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("busy_hold_stable", 32'(errs), 32'd0);
    endtask

    task automatic run(input logic [13:0] sc, input logic m, input logic w,
                       input logic [31:0] exp_outs, input string tag);
        launch(sc, m, w);
        wait_done(0, n);
        check(tag, outs(), exp_outs);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // Expected output word: {mode, win, digit, a3, a2, a1, a0}
    function automatic logic [31:0] ex(input logic m, input logic w, input logic [1:0] d,
                                       input logic [3:0] d3, input logic [3:0] d2,
                                       input logic [3:0] d1, input logic [3:0] d0);
        return {12'd0, m, w, d, d3, d2, d1, d0};
    endfunction

    initial begin
        #2;
        check("reset_outs", outs(), 32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        run(14'd0,     1'b0, 1'b0, ex(0, 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0), "score0");
        run(14'd7,     1'b1, 1'b1, ex(1, 1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd7), "score7");
        run(14'd305,   1'b0, 1'b1, ex(0, 1, 2'd2, 4'd0, 4'd3, 4'd0, 4'd5), "score305");
        run(14'd12000, 1'b1, 1'b0, ex(1, 0, 2'd3, 4'd9, 4'd9, 4'd9, 4'd9), "score12000_clamp");
        run(14'd16383, 1'b0, 1'b0, ex(0, 0, 2'd3, 4'd9, 4'd9, 4'd9, 4'd9), "score16383_clamp");
        run(14'd9999,  1'b0, 1'b0, ex(0, 0, 2'd3, 4'd9, 4'd9, 4'd9, 4'd9), "score9999");
        run(14'd1000,  1'b0, 1'b1, ex(0, 1, 2'd3, 4'd1, 4'd0, 4'd0, 4'd0), "score1000");
        run(14'd1234,  1'b0, 1'b0, ex(0, 0, 2'd3, 4'd1, 4'd2, 4'd3, 4'd4), "score1234");

        // Overlap: second start at T+5 is ignored.
        launch(14'd42, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        score = 14'd88; start = 1'b1;
        wait_done(4, n);
        check("overlap_42", outs(), ex(0, 0, 2'd1, 4'd0, 4'd0, 4'd4, 4'd2));

        // Start on the done cycle is accepted; old result held until new FINAL.
        launch(14'd88, 1'b1, 1'b0);
        check("done_cycle_start_done", {31'd0, done}, 32'd0);
        check("done_cycle_hold_42", outs(), ex(0, 0, 2'd1, 4'd0, 4'd0, 4'd4, 4'd2));
        wait_done(0, n);
        check("done_cycle_88", outs(), ex(1, 0, 2'd1, 4'd0, 4'd0, 4'd8, 4'd8));

        // Async reset mid-conversion.
        @(posedge clk); #1;
        launch(14'd9999, 1'b1, 1'b1);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 32'd0);
        check("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        check("no_done_after_rst", 32'(bad), 32'd0);
        check("outs_after_rst", outs(), 32'd0);

        run(14'd305, 1'b1, 1'b1, ex(1, 1, 2'd2, 4'd0, 4'd3, 4'd0, 4'd5), "after_rst_305");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
